// File: rtl/lc4_mul_issue.sv
// Shift-and-add multiply sequencer: walks the multiplier LSB first and issues
// one ADD (when the bit is set) / SDRL / SDRH group per bit to lc4_alu.
module lc4_mul_issue #(
  parameter int WORD_SIZE = 256,
  parameter int INSN      = 19,
  parameter int CNT_W     = 9
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_start,
  input  logic [WORD_SIZE-1:0] i_mult,
  input  logic [CNT_W-1:0]     i_count,
  input  logic [4:0]           i_rd,
  input  logic [4:0]           i_rl,
  input  logic [4:0]           i_rm,
  input  logic                 i_insn_ready,
  output logic [INSN:0]        o_insn,
  output logic                 o_insn_valid,
  output logic                 o_busy,
  output logic [CNT_W-1:0]     o_iter,
  output logic                 o_done
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_ADD  = 3'd1,
    S_SDRL = 3'd2,
    S_SDRH = 3'd3,
    S_DONE = 3'd4
  } state_t;

  localparam logic [4:0]       OP_ADD  = 5'b00101;
  localparam logic [4:0]       OP_SDRL = 5'b01111;
  localparam logic [4:0]       OP_SDRH = 5'b01110;
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(WORD_SIZE);
  localparam logic [CNT_W-1:0] ONE_CNT = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [INSN:0]    NOP     = {(INSN+1){1'b0}};

  state_t               r_state;
  state_t               w_next;
  logic [WORD_SIZE-1:0] r_m;
  logic [CNT_W-1:0]     r_rem;
  logic [CNT_W-1:0]     r_iter;
  logic [4:0]           r_rd;
  logic [4:0]           r_rl;
  logic [4:0]           r_rm;
  logic [INSN:0]        r_insn;
  logic                 r_valid;
  logic                 r_busy;
  logic                 r_done;

  logic                 w_accept;
  logic                 w_start_acc;
  logic                 w_sdrh_acc;
  logic [CNT_W-1:0]     w_load_cnt;
  logic [4:0]           w_rd;
  logic [4:0]           w_rl;
  logic [4:0]           w_rm;
  logic [INSN:0]        w_insn;
  logic                 w_valid;
  logic                 w_done;

  assign w_accept    = r_valid & i_insn_ready;
  assign w_start_acc = (r_state == S_IDLE) & i_start;
  assign w_sdrh_acc  = (r_state == S_SDRH) & w_accept;
  assign w_load_cnt  = (i_count > MAX_CNT) ? MAX_CNT : i_count;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (i_start) begin
          if (w_load_cnt == {CNT_W{1'b0}}) begin
            w_next = S_DONE;
          end else if (i_mult[0]) begin
            w_next = S_ADD;
          end else begin
            w_next = S_SDRL;
          end
        end else begin
          w_next = S_IDLE;
        end
      end
      S_ADD: begin
        if (w_accept) begin
          w_next = S_SDRL;
        end else begin
          w_next = S_ADD;
        end
      end
      S_SDRL: begin
        if (w_accept) begin
          w_next = S_SDRH;
        end else begin
          w_next = S_SDRL;
        end
      end
      S_SDRH: begin
        // Look one bit ahead: after the shift, the new M[0] is today's M[1].
        if (!w_accept) begin
          w_next = S_SDRH;
        end else if (r_rem == ONE_CNT) begin
          w_next = S_DONE;
        end else if (r_m[1]) begin
          w_next = S_ADD;
        end else begin
          w_next = S_SDRL;
        end
      end
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Outputs are precomputed from the next state so the registered word lines up with it.
  always_comb begin
    w_rd    = w_start_acc ? i_rd : r_rd;
    w_rl    = w_start_acc ? i_rl : r_rl;
    w_rm    = w_start_acc ? i_rm : r_rm;
    w_insn  = NOP;
    w_valid = 1'b0;
    w_done  = 1'b0;
    case (w_next)
      S_ADD: begin
        w_insn  = {OP_ADD, w_rd, w_rd, w_rm};
        w_valid = 1'b1;
      end
      S_SDRL: begin
        w_insn  = {OP_SDRL, w_rl, w_rd, w_rl};
        w_valid = 1'b1;
      end
      S_SDRH: begin
        w_insn  = {OP_SDRH, w_rd, w_rd, 5'b00000};
        w_valid = 1'b1;
      end
      S_DONE: begin
        w_done = 1'b1;
      end
      default: begin
        w_insn  = NOP;
        w_valid = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_m     <= {WORD_SIZE{1'b0}};
      r_rem   <= {CNT_W{1'b0}};
      r_iter  <= {CNT_W{1'b0}};
      r_rd    <= 5'd0;
      r_rl    <= 5'd0;
      r_rm    <= 5'd0;
      r_insn  <= NOP;
      r_valid <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_insn  <= w_insn;
      r_valid <= w_valid;
      r_busy  <= w_valid;
      r_done  <= w_done;
      if (w_start_acc) begin
        r_m    <= i_mult;
        r_rem  <= w_load_cnt;
        r_iter <= {CNT_W{1'b0}};
        r_rd   <= i_rd;
        r_rl   <= i_rl;
        r_rm   <= i_rm;
      end else if (w_sdrh_acc) begin
        r_m   <= {1'b0, r_m[WORD_SIZE-1:1]};
        r_rem <= r_rem - ONE_CNT;
        if (r_iter != MAX_CNT) begin
          r_iter <= r_iter + ONE_CNT;
        end else begin
          r_iter <= r_iter;
        end
      end else begin
        r_m   <= r_m;
        r_rem <= r_rem;
      end
    end
  end

  assign o_insn       = r_insn;
  assign o_insn_valid = r_valid;
  assign o_busy       = r_busy;
  assign o_iter       = r_iter;
  assign o_done       = r_done;

endmodule
